// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operation codes and burst FSM states.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_ASR  = 3'd5
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shift/rotate: next register value plus the bit that leaves it.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    input  shift_mode_t      mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             d_in,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit,
    output logic             out_vld
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] sign_fill;
    logic [AMT_W:0]   rev_amt;
    logic [AMT_W-1:0] left_idx;
    logic [AMT_W-1:0] right_idx;

    assign fill      = {WIDTH{d_in}};
    assign sign_fill = {WIDTH{q[WIDTH-1]}};
    // WIDTH-amt: the complementary shift for rotates and the index of the bit leaving on the left
    assign rev_amt   = (AMT_W+1)'(WIDTH) - {1'b0, amt};
    assign left_idx  = rev_amt[AMT_W-1:0];
    assign right_idx = amt - AMT_W'(1);

    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        out_vld = 1'b0;
        case (mode)
            MODE_SHL: begin
                q_next  = (q << amt) | (~(ONES << amt) & fill);
                out_bit = q[left_idx];
                out_vld = (amt != '0);
            end
            MODE_SHR: begin
                q_next  = (q >> amt) | (~(ONES >> amt) & fill);
                out_bit = q[right_idx];
                out_vld = (amt != '0);
            end
            MODE_ROL: begin
                q_next  = (q << amt) | (q >> rev_amt);
                out_bit = q[left_idx];
                out_vld = (amt != '0);
            end
            MODE_ROR: begin
                q_next  = (q >> amt) | (q << rev_amt);
                out_bit = q[right_idx];
                out_vld = (amt != '0);
            end
            MODE_ASR: begin
                q_next  = (q >> amt) | (~(ONES >> amt) & sign_fill);
                out_bit = q[right_idx];
                out_vld = (amt != '0);
            end
            default: begin
                q_next  = q;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, single-step shifts and counted bursts.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int CNT_W = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  shift_mode_t      mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             d_in,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d_par,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q_out,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    fsm_state_t       state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             s_reg, s_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    shift_mode_t      mode_lat_reg, mode_lat_next;
    logic [AMT_W-1:0] amt_lat_reg, amt_lat_next;
    logic             busy_reg, done_reg;

    shift_mode_t      step_mode;
    logic [AMT_W-1:0] step_amt;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;
    logic             step_vld;

    // During a burst the step uses the operation captured at start, not the live inputs
    assign step_mode = (state_reg == ST_RUN) ? mode_lat_reg : mode;
    assign step_amt  = (state_reg == ST_RUN) ? amt_lat_reg  : amt;

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .q       (q_reg),
        .mode    (step_mode),
        .amt     (step_amt),
        .d_in    (d_in),
        .q_next  (step_q),
        .out_bit (step_bit),
        .out_vld (step_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            q_reg        <= '0;
            s_reg        <= 1'b0;
            cnt_reg      <= '0;
            mode_lat_reg <= MODE_HOLD;
            amt_lat_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            q_reg        <= q_next;
            s_reg        <= s_next;
            cnt_reg      <= cnt_next;
            mode_lat_reg <= mode_lat_next;
            amt_lat_reg  <= amt_lat_next;
            busy_reg     <= (state_next == ST_RUN);
            done_reg     <= (state_next == ST_FIN);
        end
    end

    always_comb begin
        state_next    = state_reg;
        q_next        = q_reg;
        s_next        = s_reg;
        cnt_next      = cnt_reg;
        mode_lat_next = mode_lat_reg;
        amt_lat_next  = amt_lat_reg;
        if (load) begin
            // A load wins over everything and silently abandons a burst
            q_next     = d_par;
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            mode_lat_next = mode;
                            amt_lat_next  = amt;
                            cnt_next      = burst_len;
                            state_next    = ST_RUN;
                        end else begin
                            state_next = ST_FIN;
                        end
                    end else if (en) begin
                        q_next = step_q;
                        if (step_vld) s_next = step_bit;
                    end
                end
                ST_RUN: begin
                    q_next   = step_q;
                    if (step_vld) s_next = step_bit;
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) state_next = ST_FIN;
                end
                ST_FIN: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign q_out = q_reg;
    assign s_out = s_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: a bit-level reference model predicts each cycle; a monitor compares after each edge.
module tb_univ_shift_reg;
    import shift_pkg::*;

    localparam int W     = 16;
    localparam int AW    = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    shift_mode_t   mode = MODE_HOLD;
    logic [AW-1:0] amt = '0;
    logic          d_in = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  d_par = '0;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic [W-1:0]  q_out;
    logic          s_out;
    logic          busy;
    logic          done;

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .amt       (amt),
        .d_in      (d_in),
        .en        (en),
        .load      (load),
        .d_par     (d_par),
        .start     (start),
        .burst_len (burst_len),
        .q_out     (q_out),
        .s_out     (s_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         s;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model state: register contents, out bit, and the burst bookkeeping
    logic [W-1:0] m_q = '0;
    logic         m_s = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_left = 0;
    int           m_mode = 0;
    int           m_amt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One step defined bit by bit: where each result bit comes from
    task automatic model_step(input int code, input int k, input logic d);
        logic [W-1:0] nq;
        nq = m_q;
        if (code >= 1 && code <= 5) begin
            for (int i = 0; i < W; i++) begin
                case (code)
                    1: nq[i] = (i >= k) ? m_q[i-k] : d;
                    2: nq[i] = (i + k < W) ? m_q[i+k] : d;
                    3: nq[i] = m_q[(i - k + W) % W];
                    4: nq[i] = m_q[(i + k) % W];
                    default: nq[i] = (i + k < W) ? m_q[i+k] : m_q[W-1];
                endcase
            end
            if (k != 0) m_s = (code == 1 || code == 3) ? m_q[W-k] : m_q[k-1];
        end
        m_q = nq;
    endtask

    task automatic model_edge();
        logic nd;
        nd = 1'b0;
        if (load) begin
            m_q = d_par; m_busy = 1'b0; m_left = 0;
        end else if (m_busy) begin
            model_step(m_mode, m_amt, d_in);
            m_left--;
            if (m_left == 0) begin m_busy = 1'b0; nd = 1'b1; end
        end else if (m_done) begin
            nd = 1'b0;
        end else if (start) begin
            if (burst_len != 0) begin
                m_mode = int'(mode); m_amt = int'(amt); m_left = int'(burst_len); m_busy = 1'b1;
            end else begin
                nd = 1'b1;
            end
        end else if (en) begin
            model_step(int'(mode), int'(amt), d_in);
        end
        m_done = nd;
    endtask

    // Predict, queue the expectation, then let the edge happen; inputs change 2 units later
    task automatic tick();
        model_edge();
        sb.push_back({m_q, m_s, m_busy, m_done});
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        en = 1'b0; load = 1'b0; start = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb_q_out", 32'(q_out), 32'(mon_e.q));
            chk("sb_s_out", 32'(s_out), 32'(mon_e.s));
            chk("sb_busy",  32'(busy),  32'(mon_e.busy));
            chk("sb_done",  32'(done),  32'(mon_e.done));
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_q", 32'(q_out), 0);
        chk("rst_s", 32'(s_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        $display("txn reset: q_out=%h", q_out);

        // Rotate left by one across the boundary
        load = 1'b1; d_par = 16'h8001; tick();
        load = 1'b0; en = 1'b1; mode = MODE_ROL; amt = 4'd1; tick();
        idle_inputs();
        chk("rol_q", 32'(q_out), 32'h0003);
        chk("rol_s", 32'(s_out), 1);
        $display("txn rol: q_out=%h s_out=%b", q_out, s_out);

        // Arithmetic shift keeps the sign
        load = 1'b1; d_par = 16'h8000; tick();
        load = 1'b0; en = 1'b1; mode = MODE_ASR; amt = 4'd4; tick();
        idle_inputs();
        chk("asr_q", 32'(q_out), 32'hF800);
        chk("asr_s", 32'(s_out), 0);
        $display("txn asr: q_out=%h s_out=%b", q_out, s_out);

        // Full-width burst filling with ones; live mode/amt changes must not matter
        load = 1'b1; d_par = '0; tick();
        load = 1'b0; start = 1'b1; mode = MODE_SHL; amt = 4'd1; d_in = 1'b1; burst_len = 8'd16; tick();
        start = 1'b0; mode = MODE_HOLD; amt = 4'd0; en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("burst_busy", 32'(busy), 1);
            chk("burst_nodone", 32'(done), 0);
            tick();
        end
        chk("burst_q", 32'(q_out), 32'hFFFF);
        chk("burst_done", 32'(done), 1);
        chk("burst_busy_end", 32'(busy), 0);
        tick();
        chk("burst_done_pulse", 32'(done), 0);
        idle_inputs();
        $display("txn burst16: q_out=%h", q_out);

        // Zero-length burst
        load = 1'b1; d_par = 16'h5A5A; tick();
        load = 1'b0; start = 1'b1; burst_len = 8'd0; mode = MODE_SHL; amt = 4'd3; tick();
        start = 1'b0;
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_q", 32'(q_out), 32'h5A5A);
        tick();
        chk("zero_done_pulse", 32'(done), 0);
        $display("txn zero_len: q_out=%h", q_out);

        // Load aborts a running burst
        start = 1'b1; mode = MODE_SHR; amt = 4'd1; d_in = 1'b0; burst_len = 8'd8; tick();
        start = 1'b0;
        repeat (2) tick();
        load = 1'b1; d_par = 16'h1234; tick();
        load = 1'b0;
        chk("abort_q", 32'(q_out), 32'h1234);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        repeat (10) begin
            tick();
            chk("abort_no_done", 32'(done), 0);
        end
        $display("txn abort: q_out=%h", q_out);

        // Asynchronous reset in the middle of a burst
        load = 1'b1; d_par = 16'hBEEF; tick();
        load = 1'b0; start = 1'b1; mode = MODE_ROR; amt = 4'd3; burst_len = 8'd10; tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_q", 32'(q_out), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_s", 32'(s_out), 0);
        m_q = '0; m_s = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_mode = 0; m_amt = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (12) begin
            tick();
            chk("post_rst_no_done", 32'(done), 0);
        end
        $display("txn mid_reset: q_out=%h", q_out);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            load      = ($urandom_range(0, 19) == 0);
            start     = ($urandom_range(0, 7) == 0);
            en        = ($urandom_range(0, 1) == 1);
            mode      = shift_mode_t'(3'($urandom_range(0, 7)));
            amt       = 4'($urandom_range(0, 15));
            d_in      = 1'($urandom_range(0, 1));
            burst_len = 8'($urandom_range(0, 12));
            d_par     = 16'($urandom);
            tick();
        end
        idle_inputs();
        tick();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register width (>=2).
REQ-002 SHALL have parameter CNT_W, default 8, burst-length counter width.
REQ-003 SHALL derive localparam AMT_W = $clog2(WIDTH).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 mode  in  3  operation select (shift_mode_t).
REQ-007 amt  in  AMT_W  shift distance per step, 0..WIDTH-1.
REQ-008 d_in  in  1  fill bit for SHL/SHR vacated positions.
REQ-009 en  in  1  single-step enable.
REQ-010 load  in  1  parallel load strobe.
REQ-011 d_par  in  WIDTH  parallel load data.
REQ-012 start  in  1  burst start strobe.
REQ-013 burst_len  in  CNT_W  number of steps in burst.
REQ-014 q_out  out  WIDTH  register contents.
REQ-015 s_out  out  1  registered copy of the last bit shifted or rotated out.
REQ-016 busy  out  1  burst in progress.
REQ-017 done  out  1  one-cycle pulse at burst completion.

Function
REQ-018 Modes SHALL be: HOLD=0, SHL=1, SHR=2, ROL=3, ROR=4, ASR=5; codes 6-7 SHALL act as HOLD.
REQ-019 A step of amt=k SHALL be: SHL q<<k, low k bits = d_in; SHR q>>k, high k bits = d_in; ROL/ROR rotate by k; ASR q>>k, high k bits = q[WIDTH-1].
REQ-020 Per step, s_out SHALL take q[WIDTH-k] (SHL/ROL) or q[k-1] (SHR/ROR/ASR), pre-step value; for k=0 or HOLD, s_out SHALL hold.
REQ-021 Priority per cycle SHALL be: load > active burst step > en step > hold.
REQ-022 load SHALL set q_out=d_par next edge, leave s_out unchanged, and abort any burst (busy->0, no done).
REQ-023 FSM states SHALL be IDLE, RUN, FIN.
REQ-024 IDLE: start with burst_len>0 and no load SHALL latch mode, amt, burst_len into internal registers and go to RUN; busy=1 from next cycle.
REQ-025 IDLE: start with burst_len=0 SHALL go to FIN with no shift.
REQ-026 RUN: one step per cycle using latched mode/amt and live d_in; counter decrements; after the step leaving the count at 0, go to FIN.
REQ-027 FIN: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-028 A burst of burst_len=L SHALL perform exactly L steps over L consecutive cycles, with done asserted in the cycle after the last step.
REQ-029 start and en while busy or in FIN SHALL be ignored; mode/amt changes during RUN SHALL have no effect.
REQ-030 en in IDLE with no load/start SHALL perform one step using live mode/amt; start and en together in IDLE: start wins, en ignored.
REQ-031 amt=0 steps SHALL count toward burst length and leave q_out unchanged.

Reset
REQ-032 rst=1 SHALL immediately force q_out=0, s_out=0, busy=0, done=0, FSM=IDLE, counter=0, latched mode=HOLD, latched amt=0, including mid-burst.
REQ-033 After rst deassertion the first active edge SHALL obey normal priority.

Structure
REQ-034 Package shift_pkg SHALL hold shift_mode_t enum and fsm state enum.
REQ-035 Combinational step function SHALL be sub-module shift_step (inputs q, mode, amt, d_in; outputs next q, out bit), instantiated once.
REQ-036 Single file per module; no latches; all outputs registered.

Verification (WIDTH=16)
REQ-037 Reset: assert rst mid-burst (L=10, cycle 4) -> same time q_out=0, busy=0, done=0, s_out=0; no done later.
REQ-038 Rotate: load 16'h8001, then en, ROL, amt=1 -> q_out=16'h0003, s_out=1.
REQ-039 Arithmetic: load 16'h8000, en, ASR, amt=4 -> q_out=16'hF800, s_out=0.
REQ-040 Burst: from 0, start SHL, amt=1, d_in=1, L=16 -> busy 16 cycles, q_out=16'hFFFF, one-cycle done pulse next cycle.
REQ-041 Zero-length: start with L=0 -> done next cycle, q_out unchanged, busy never 1.
REQ-042 Abort: start SHR, L=8; load 16'h1234 at cycle 3 -> q_out=16'h1234, busy=0, no done.
